// File: rtl/ni_pkg.sv
// Shared types for the ejection network interface: flit type encoding and framing FSM states.
// The default flit width is 18 bits (16-bit payload plus 2-bit type field).
package ni_pkg;
  localparam int NI_DW = 18;
  localparam int TYPE_MSB = NI_DW - 1;
  localparam int TYPE_LSB = NI_DW - 2;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HEAD   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PKT  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    PKT  = ST_PKT
  } ni_state_e;
endpackage

// File: rtl/ni_sync_fifo.sv
// Synchronous FIFO whose head is read straight from storage registers, so a push becomes
// visible on rdata one cycle later with no write-through bypass.
module ni_sync_fifo #(
   parameter int DW    = 18,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // Storage needs no reset; count/empty qualify every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
endmodule

// File: rtl/noc_eject_ni.sv
// Router local-port ejection NI: buffers flits, returns one credit per freed slot and
// re-frames the flit stream into sop/eop packets. Optional counters under NI_STATS_EN.
module noc_eject_ni
   import ni_pkg::*;
#(
   parameter int DW    = NI_DW,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] flit_data,
   input  logic          flit_valid,
   output logic          flit_ready,
   output logic          credit_upd,
   output logic [DW-3:0] pkt_data,
   output logic          pkt_sop,
   output logic          pkt_eop,
   output logic          pkt_valid,
   input  logic          pkt_ready,
   output logic          proto_err,
`ifdef NI_STATS_EN
   output logic [15:0]   stat_pkts,
   output logic [15:0]   stat_drops,
`endif
   output logic [0:0]    dbg_state
);
   // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
   // a source holds its data stable while valid is high and ready is low.
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

   logic [DW-1:0] head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   count;
   flit_type_e    head_type;
   ni_state_e     state;
   logic          head_vld, drop, emit, pop, push, is_start, is_end, ready_nxt;

   ni_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (flit_data),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign head_type = flit_type_e'(head[DW-1:DW-2]);
   assign is_start  = (head_type == HEAD) || (head_type == SINGLE);
   assign is_end    = (head_type == TAIL) || (head_type == SINGLE);

   // Stray BODY/TAIL outside a packet is discarded without waiting for the PE.
   assign head_vld  = !rst && !fifo_empty;
   assign drop      = head_vld && (state == IDLE) && !is_start;
   assign pkt_valid = head_vld && !drop;
   assign emit      = pkt_valid && pkt_ready;
   assign pop       = drop || emit;
   assign push      = flit_valid && flit_ready;

   assign pkt_sop   = pkt_valid && is_start;
   assign pkt_eop   = pkt_valid && is_end;
   assign pkt_data  = pkt_valid ? head[DW-3:0] : '0;
   assign dbg_state = state;

   // Ready for next cycle reflects the occupancy after this cycle's push/pop.
   assign ready_nxt = !((fifo_full && !pop) || ((count == DEPTH_M1) && push && !pop));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         flit_ready <= 1'b0;
         credit_upd <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         flit_ready <= ready_nxt;
         credit_upd <= pop;
         if (drop || (emit && (state == PKT) && is_start)) proto_err <= 1'b1;
         if (emit) begin
            if (head_type == HEAD)  state <= PKT;
            else if (is_end)        state <= IDLE;
         end
      end
   end

`ifdef NI_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_pkts  <= '0;
         stat_drops <= '0;
      end else begin
         if (emit && is_end && (stat_pkts != 16'hFFFF))  stat_pkts  <= stat_pkts + 16'd1;
         if (drop && (stat_drops != 16'hFFFF))           stat_drops <= stat_drops + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_noc_eject_ni.sv
// Bench for noc_eject_ni: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic. Honours NI_STATS_EN.
module tb_noc_eject_ni;
   import ni_pkg::*;

   localparam int DW    = NI_DW;
   localparam int DEPTH = 4;
   localparam int PW    = DW - 2;

   logic          clk;
   logic          rst;
   logic [DW-1:0] flit_data;
   logic          flit_valid;
   logic          flit_ready;
   logic          credit_upd;
   logic [PW-1:0] pkt_data;
   logic          pkt_sop;
   logic          pkt_eop;
   logic          pkt_valid;
   logic          pkt_ready;
   logic          proto_err;
   logic [0:0]    dbg_state;
`ifdef NI_STATS_EN
   logic [15:0]   stat_pkts;
   logic [15:0]   stat_drops;
`endif

   noc_eject_ni #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .flit_data  (flit_data),
      .flit_valid (flit_valid),
      .flit_ready (flit_ready),
      .credit_upd (credit_upd),
      .pkt_data   (pkt_data),
      .pkt_sop    (pkt_sop),
      .pkt_eop    (pkt_eop),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .proto_err  (proto_err),
`ifdef NI_STATS_EN
      .stat_pkts  (stat_pkts),
      .stat_drops (stat_drops),
`endif
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_hd;
   flit_type_e    m_ty;
   bit            m_in_pkt, m_err, m_credit, m_ready, started;
   bit            m_has, m_stray, m_emit, m_pop;
   int            m_pkts, m_drops;

   initial begin
      m_in_pkt = 0; m_err = 0; m_credit = 0; m_ready = 0; started = 0;
      m_pkts = 0; m_drops = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_q.delete();
            m_in_pkt = 0; m_err = 0; m_credit = 0; m_ready = 0;
            m_pkts = 0; m_drops = 0;
         end else begin
            m_has = (m_q.size() > 0);
            m_ty  = BODY;
            if (m_has) begin
               m_hd = m_q[0];
               m_ty = flit_type_e'(m_hd[DW-1:DW-2]);
            end
            m_stray = m_has && !m_in_pkt && (m_ty == BODY || m_ty == TAIL);
            m_emit  = m_has && !m_stray && pkt_ready;
            m_pop   = m_stray || m_emit;
            if (m_stray) begin
               m_err = 1;
               if (m_drops < 65535) m_drops++;
            end
            if (m_emit) begin
               if (m_in_pkt && (m_ty == HEAD || m_ty == SINGLE)) m_err = 1;
               if ((m_ty == TAIL || m_ty == SINGLE) && m_pkts < 65535) m_pkts++;
               case (m_ty)
                  HEAD:    m_in_pkt = 1;
                  BODY:    m_in_pkt = m_in_pkt;
                  default: m_in_pkt = 0;
               endcase
            end
            if (m_pop) void'(m_q.pop_front());
            if (flit_valid && m_ready) m_q.push_back(flit_data);
            m_credit = m_pop;
            m_ready  = (m_q.size() < DEPTH);
         end
         started = 1;
      end
   end

   // ---------------- compare process + DUT observation ----------------
   logic [PW+1:0] obs_q[$];
   int            cred_cnt = 0;
   int            acc_cnt  = 0;
   bit            e_valid;
   logic [DW-1:0] e_hd;
   flit_type_e    e_ty;

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            e_valid = 0;
            e_ty    = BODY;
            if (!rst && m_q.size() > 0) begin
               e_hd    = m_q[0];
               e_ty    = flit_type_e'(e_hd[DW-1:DW-2]);
               e_valid = m_in_pkt || e_ty == HEAD || e_ty == SINGLE;
            end
            chk("flit_ready", flit_ready, m_ready);
            chk("credit_upd", credit_upd, m_credit);
            chk("proto_err", proto_err, m_err);
            chk("pkt_valid", pkt_valid, e_valid);
            chk("dbg_state", dbg_state, m_in_pkt);
            if (e_valid) begin
               chk("pkt_sop", pkt_sop, (e_ty == HEAD || e_ty == SINGLE));
               chk("pkt_eop", pkt_eop, (e_ty == TAIL || e_ty == SINGLE));
               chk("pkt_data", pkt_data, e_hd[PW-1:0]);
            end
`ifdef NI_STATS_EN
            chk("stat_pkts", stat_pkts, m_pkts[15:0]);
            chk("stat_drops", stat_drops, m_drops[15:0]);
`endif
         end
         if (credit_upd === 1'b1) cred_cnt++;
         if (pkt_valid === 1'b1 && pkt_ready === 1'b1) obs_q.push_back({pkt_sop, pkt_eop, pkt_data});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [1:0] ty, input logic [PW-1:0] pl);
      bit r;
      int n;
      flit_data  = {ty, pl};
      flit_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         r = flit_ready;
         @(posedge clk);
         #1;
         if (r) begin
            acc_cnt++;
            break;
         end
         n++;
         if (n > 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept_within_200 t=%0t", $time);
            break;
         end
      end
      flit_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      idle(n);
      rst = 1'b0;
      cred_cnt = 0;
      acc_cnt  = 0;
   endtask

   bit rnd_rdy = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_rdy) pkt_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // ---------------- scenarios ----------------
   int c0, o0;

   initial begin
      rst = 1'b1; flit_valid = 1'b0; flit_data = '0; pkt_ready = 1'b0;

      // Reset behaviour
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_flit_ready", flit_ready, 1'b0);
      chk("rst_credit_upd", credit_upd, 1'b0);
      chk("rst_pkt_valid", pkt_valid, 1'b0);
      chk("rst_proto_err", proto_err, 1'b0);
      @(posedge clk);
      #1;
      do_reset(0);
      idle(1);
      chk("ready_after_rst", flit_ready, 1'b1);

      // Clean three-flit packet
      pkt_ready = 1'b1;
      c0 = cred_cnt; o0 = obs_q.size();
      send(2'b10, PW'(32'hA0));
      send(2'b00, PW'(32'hA1));
      send(2'b01, PW'(32'hA2));
      idle(4);
      chk("pkt_count", obs_q.size() - o0, 3);
      chk("pkt_f0", obs_q[o0],   {2'b10, PW'(32'hA0)});
      chk("pkt_f1", obs_q[o0+1], {2'b00, PW'(32'hA1)});
      chk("pkt_f2", obs_q[o0+2], {2'b01, PW'(32'hA2)});
      chk("pkt_credits", cred_cnt - c0, 3);
      chk("pkt_proto_err", proto_err, 1'b0);

      // Backpressure: FIFO fills at DEPTH, fifth flit waits for a pop
      pkt_ready = 1'b0;
      c0 = cred_cnt; o0 = obs_q.size();
      send(2'b10, PW'(32'hC0));
      send(2'b00, PW'(32'hC1));
      send(2'b00, PW'(32'hC2));
      send(2'b00, PW'(32'hC3));
      @(negedge clk);
      chk("bp_full_ready", flit_ready, 1'b0);
      chk("bp_no_credit", cred_cnt - c0, 0);
      chk("bp_head_valid", pkt_valid, 1'b1);
      #4;
      fork
         send(2'b01, PW'(32'hC4));
         begin
            idle(3);
            pkt_ready = 1'b1;
         end
      join
      idle(8);
      chk("bp_credits", cred_cnt - c0, 5);
      chk("bp_emitted", obs_q.size() - o0, 5);
      chk("bp_last", obs_q[o0+4], {2'b01, PW'(32'hC4)});

      // Stray BODY in IDLE then SINGLE
      c0 = cred_cnt; o0 = obs_q.size();
      send(2'b00, PW'(32'hD0));
      send(2'b11, PW'(32'hBB));
      idle(4);
      chk("frm_credits", cred_cnt - c0, 2);
      chk("frm_emitted", obs_q.size() - o0, 1);
      chk("frm_single", obs_q[o0], {2'b11, PW'(32'hBB)});
      chk("frm_proto_err", proto_err, 1'b1);
      chk("frm_model_err", m_err, 1'b1);

      // Reset in the middle of a packet
      pkt_ready = 1'b0;
      send(2'b10, PW'(32'hE0));
      send(2'b00, PW'(32'hE1));
      do_reset(1);
      @(negedge clk);
      chk("mid_rst_valid", pkt_valid, 1'b0);
      chk("mid_rst_err", proto_err, 1'b0);
      chk("mid_rst_credits", cred_cnt, 0);
      #4;
      pkt_ready = 1'b1;
      o0 = obs_q.size();
      send(2'b10, PW'(32'hE2));
      idle(2);
      chk("mid_rst_head", obs_q[o0], {2'b10, PW'(32'hE2)});
      chk("mid_rst_err2", proto_err, 1'b0);
      send(2'b01, PW'(32'hE3));
      idle(3);

`ifdef NI_STATS_EN
      // Statistics counters
      do_reset(1);
      idle(1);
      send(2'b11, PW'(32'h1));
      send(2'b01, PW'(32'h2));
      send(2'b11, PW'(32'h3));
      send(2'b01, PW'(32'h4));
      send(2'b11, PW'(32'h5));
      idle(4);
      chk("stat_pkts_lit", stat_pkts, 16'd3);
      chk("stat_drops_lit", stat_drops, 16'd2);
`endif

      // Randomized traffic with random PE backpressure
      rnd_rdy = 1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send(2'($urandom_range(0, 3)), PW'($urandom));
      end
      rnd_rdy = 0;
      #1;
      pkt_ready = 1'b1;
      idle(20);
      chk("drain_credits_eq_accepted", cred_cnt, acc_cnt);
      chk("drain_valid", pkt_valid, 1'b0);
      chk("drain_ready", flit_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
